// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the ARMv4 instruction encoder: op encodings,
// condition constants and the load-session state machine encoding.
package instr_encoder_pkg;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;

    localparam logic [3:0] AL = 4'hE;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCEPT,
        S_DRAIN,
        S_DONE
    } state_e;

endpackage

// File: rtl/instr_encoder_if.sv
// Field-set input handshake plus the auto-incrementing imem write port.
interface instr_encoder_if #(
    parameter int ADDR_W = 6
);
    logic              in_valid;
    logic              in_ready;
    logic              in_last;
    logic [3:0]        cond;
    logic [1:0]        op;
    logic [5:0]        funct;
    logic [3:0]        rn;
    logic [3:0]        rd;
    logic [11:0]       src2;
    logic [23:0]       imm24;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    modport master (
        output in_valid, in_last, cond, op, funct, rn, rd, src2, imm24,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, in_last, cond, op, funct, rn, rd, src2, imm24,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/instr_encoder_pack.sv
// Combinational packer: decoded ARMv4 fields -> 32-bit instruction word.
module instr_pack
    import instr_encoder_pkg::*;
(
    input  logic [3:0]  cond,
    input  logic [1:0]  op,
    input  logic [5:0]  funct,
    input  logic [3:0]  rn,
    input  logic [3:0]  rd,
    input  logic [11:0] src2,
    input  logic [23:0] imm24,
    output logic [31:0] word,
    output logic        illegal
);

    always_comb begin
        word    = '0;
        illegal = 1'b0;
        case (op)
            OP_DP, OP_MEM: word = {cond, op, funct, rn, rd, src2};
            OP_BR:         word = {cond, OP_BR, funct[5:4], imm24};
            default:       illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Sequential ARMv4 instruction encoder: accepts field sets, packs them and
// streams the words into imem through a one-deep write stage.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int ADDR_W    = 6,
    parameter int BASE_ADDR = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    instr_encoder_if.slave  bus,
    output logic            busy,
    output logic            done,
    output logic            full,
    output logic            err,
    output logic [ADDR_W:0] count
);

    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   LAST_IDX = {1'b0, {ADDR_W{1'b1}}};

    state_e            state_q, state_d;
    logic              stage_vld_q, stage_vld_d;
    logic [31:0]       stage_word_q, stage_word_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              full_q, full_d;
    logic              err_q, err_d;

    logic [31:0] pk_word;
    logic        pk_illegal;
    logic        in_ready;
    logic        hs;
    logic        last_slot;

    instr_pack u_pack (
        .cond    (bus.cond),
        .op      (bus.op),
        .funct   (bus.funct),
        .rn      (bus.rn),
        .rd      (bus.rd),
        .src2    (bus.src2),
        .imm24   (bus.imm24),
        .word    (pk_word),
        .illegal (pk_illegal)
    );

    always_comb begin
        state_d      = state_q;
        stage_vld_d  = 1'b0;
        stage_word_d = stage_word_q;
        ptr_d        = ptr_q;
        count_d      = count_q;
        full_d       = full_q;
        err_d        = err_q;

        in_ready  = (state_q == S_ACCEPT);
        hs        = bus.in_valid & in_ready;
        // Index of the word a handshake now would stage, counting the pending one.
        last_slot = (count_q + {{ADDR_W{1'b0}}, stage_vld_q}) == LAST_IDX;

        if (stage_vld_q) begin
            ptr_d   = ptr_q + ADDR_W'(1);
            count_d = count_q + (ADDR_W+1)'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ACCEPT;
                    full_d  = 1'b0;
                    err_d   = 1'b0;
                    count_d = '0;
                    ptr_d   = BASE;
                end
            end
            S_ACCEPT: begin
                if (hs) begin
                    if (pk_illegal) begin
                        err_d = 1'b1;
                        if (bus.in_last) state_d = S_DRAIN;
                    end else begin
                        stage_vld_d  = 1'b1;
                        stage_word_d = pk_word;
                        if (bus.in_last) begin
                            state_d = S_DRAIN;
                        end else if (last_slot) begin
                            full_d  = 1'b1;
                            state_d = S_DRAIN;
                        end
                    end
                end
            end
            S_DRAIN: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            stage_vld_q  <= 1'b0;
            stage_word_q <= '0;
            ptr_q        <= BASE;
            count_q      <= '0;
            full_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            stage_vld_q  <= stage_vld_d;
            stage_word_q <= stage_word_d;
            ptr_q        <= ptr_d;
            count_q      <= count_d;
            full_q       <= full_d;
            err_q        <= err_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.mem_we    = stage_vld_q;
    assign bus.mem_addr  = ptr_q;
    assign bus.mem_wdata = stage_word_q;
    assign busy          = (state_q == S_ACCEPT) || (state_q == S_DRAIN);
    assign done          = (state_q == S_DONE);
    assign full          = full_q;
    assign err           = err_q;
    assign count         = count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: a default-size instance plus an ADDR_W=2
// instance sharing the same stimulus, used for the imem-full scenario.
module tb_instr_encoder;
    import instr_encoder_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    always #5 clk = ~clk;

    logic        in_valid = 1'b0;
    logic        in_last  = 1'b0;
    logic [3:0]  cond  = '0;
    logic [1:0]  op    = '0;
    logic [5:0]  funct = '0;
    logic [3:0]  rn    = '0;
    logic [3:0]  rd    = '0;
    logic [11:0] src2  = '0;
    logic [23:0] imm24 = '0;
    logic        use_small = 1'b0;

    instr_encoder_if #(.ADDR_W(6)) bb ();
    instr_encoder_if #(.ADDR_W(2)) sb ();

    assign bb.in_valid = in_valid;  assign sb.in_valid = in_valid;
    assign bb.in_last  = in_last;   assign sb.in_last  = in_last;
    assign bb.cond     = cond;      assign sb.cond     = cond;
    assign bb.op       = op;        assign sb.op       = op;
    assign bb.funct    = funct;     assign sb.funct    = funct;
    assign bb.rn       = rn;        assign sb.rn       = rn;
    assign bb.rd       = rd;        assign sb.rd       = rd;
    assign bb.src2     = src2;      assign sb.src2     = src2;
    assign bb.imm24    = imm24;     assign sb.imm24    = imm24;

    logic       b_busy, b_done, b_full, b_err;
    logic [6:0] b_count;
    logic       s_busy, s_done, s_full, s_err;
    logic [2:0] s_count;

    instr_encoder #(.ADDR_W(6), .BASE_ADDR(0)) u_big (
        .clk(clk), .rst(rst), .start(start), .bus(bb),
        .busy(b_busy), .done(b_done), .full(b_full), .err(b_err), .count(b_count)
    );

    instr_encoder #(.ADDR_W(2), .BASE_ADDR(0)) u_small (
        .clk(clk), .rst(rst), .start(start), .bus(sb),
        .busy(s_busy), .done(s_done), .full(s_full), .err(s_err), .count(s_count)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [5:0]  bw_addr[$];
    logic [31:0] bw_data[$];
    int          bw_cyc[$];
    logic [1:0]  sw_addr[$];
    logic [31:0] sw_data[$];
    int          b_dones = 0;
    int          s_dones = 0;

    // Mid-cycle capture of every imem write and done pulse.
    always @(negedge clk) begin
        if (bb.mem_we) begin
            bw_addr.push_back(bb.mem_addr);
            bw_data.push_back(bb.mem_wdata);
            bw_cyc.push_back(cyc);
        end
        if (sb.mem_we) begin
            sw_addr.push_back(sb.mem_addr);
            sw_data.push_back(sb.mem_wdata);
        end
        if (b_done) b_dones++;
        if (s_done) s_dones++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        bw_addr.delete(); bw_data.delete(); bw_cyc.delete();
        sw_addr.delete(); sw_data.delete();
        b_dones = 0;
        s_dones = 0;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    // Presents one field set and waits (bounded) for the handshake edge.
    task automatic send(input logic [1:0] o, input logic [5:0] f, input logic [3:0] n,
                        input logic [3:0] d, input logic [11:0] s2, input logic [23:0] i24,
                        input logic last, output logic acc);
        cond = AL; op = o; funct = f; rn = n; rd = d; src2 = s2; imm24 = i24;
        in_last = last; in_valid = 1'b1; acc = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (use_small ? sb.in_ready : bb.in_ready) begin
                acc = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    logic acc;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_flags", {b_busy, b_done, b_full, b_err, bb.mem_we, bb.in_ready}, 6'b0);
        check("rst_count", b_count, 0);
        check("rst_addr", bb.mem_addr, 0);
        check("rst_wdata", bb.mem_wdata, 0);
        @(posedge clk); #1 rst = 1'b1;

        // Single ADD with in_last
        clear_mon();
        pulse_start();
        send(OP_DP, 6'b101000, 4'd2, 4'd1, 12'h005, 24'h0, 1'b1, acc);
        check("add_acc", acc, 1);
        @(negedge clk);
        check("add_we", bb.mem_we, 1);
        check("add_addr", bb.mem_addr, 0);
        check("add_wdata", bb.mem_wdata, 32'hE2821005);
        repeat (4) @(negedge clk);
        check("add_done", b_dones, 1);
        check("add_count", b_count, 1);
        check("add_nwr", bw_addr.size(), 1);
        check("add_busy", b_busy, 0);

        // Back-to-back LDR then branch
        clear_mon();
        pulse_start();
        send(OP_MEM, 6'b011001, 4'd4, 4'd3, 12'h008, 24'h0, 1'b0, acc);
        check("ldr_acc", acc, 1);
        send(OP_BR, 6'b100000, 4'd0, 4'd0, 12'h000, 24'hFFFFFE, 1'b1, acc);
        check("br_acc", acc, 1);
        repeat (4) @(negedge clk);
        check("lb_nwr", bw_addr.size(), 2);
        check("lb_addr0", bw_addr[0], 0);
        check("lb_data0", bw_data[0], 32'hE5943008);
        check("lb_addr1", bw_addr[1], 1);
        check("lb_data1", bw_data[1], 32'hEAFFFFFE);
        check("lb_consec", bw_cyc[1] - bw_cyc[0], 1);
        check("lb_count", b_count, 2);
        check("lb_done", b_dones, 1);

        // Illegal op mid-stream
        clear_mon();
        pulse_start();
        send(OP_DP, 6'b101000, 4'd2, 4'd1, 12'h005, 24'h0, 1'b0, acc);
        send(OP_ILL, 6'b000000, 4'd0, 4'd0, 12'h000, 24'h0, 1'b0, acc);
        check("ill_acc", acc, 1);
        send(OP_DP, 6'b000100, 4'd3, 4'd3, 12'h001, 24'h0, 1'b1, acc);
        repeat (4) @(negedge clk);
        check("ill_nwr", bw_addr.size(), 2);
        check("ill_addr0", bw_addr[0], 0);
        check("ill_data0", bw_data[0], 32'hE2821005);
        check("ill_addr1", bw_addr[1], 1);
        check("ill_data1", bw_data[1], 32'hE0433001);
        check("ill_err", b_err, 1);
        check("ill_count", b_count, 2);
        check("ill_done", b_dones, 1);
        pulse_start();
        @(negedge clk);
        check("ill_err_clr", b_err, 0);
        check("ill_cnt_clr", b_count, 0);
        send(OP_DP, 6'b101000, 4'd2, 4'd1, 12'h005, 24'h0, 1'b1, acc);
        repeat (4) @(negedge clk);

        // start held high through ACCEPT
        clear_mon();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1;
        send(OP_DP, 6'b101000, 4'd2, 4'd1, 12'h005, 24'h0, 1'b0, acc);
        send(OP_MEM, 6'b011001, 4'd4, 4'd3, 12'h008, 24'h0, 1'b1, acc);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("sh_nwr", bw_addr.size(), 2);
        check("sh_addr0", bw_addr[0], 0);
        check("sh_addr1", bw_addr[1], 1);
        check("sh_data1", bw_data[1], 32'hE5943008);
        check("sh_count", b_count, 2);
        check("sh_done", b_dones, 1);

        // imem full on the ADDR_W=2 instance
        use_small = 1'b1;
        clear_mon();
        pulse_start();
        for (int k = 0; k < 4; k++) begin
            send(OP_DP, 6'b101000, 4'd2, 4'(k + 1), 12'h005, 24'h0, 1'b0, acc);
            check("full_acc", acc, 1);
        end
        @(negedge clk);
        check("full_rdy_low", sb.in_ready, 0);
        check("full_we", sb.mem_we, 1);
        check("full_addr3", sb.mem_addr, 3);
        send(OP_DP, 6'b101000, 4'd2, 4'd5, 12'h005, 24'h0, 1'b0, acc);
        check("full_5th_rej", acc, 0);
        repeat (2) @(negedge clk);
        check("full_nwr", sw_addr.size(), 4);
        for (int k = 0; k < 4; k++) begin
            check("full_addr", sw_addr[k], k);
            check("full_data", sw_data[k], 32'hE2820005 | ((k + 1) << 12));
        end
        check("full_flag", s_full, 1);
        check("full_count", s_count, 4);
        check("full_done", s_dones, 1);
        check("full_busy", s_busy, 0);
        use_small = 1'b0;

        // Reset mid-session with a staged word
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        clear_mon();
        pulse_start();
        send(OP_DP, 6'b101000, 4'd2, 4'd1, 12'h005, 24'h0, 1'b0, acc);
        check("rm_acc", acc, 1);
        #1 rst = 1'b0;
        #1;
        check("rm_we", bb.mem_we, 0);
        check("rm_flags", {b_busy, b_done, b_full, b_err, bb.in_ready}, 5'b0);
        check("rm_count", b_count, 0);
        check("rm_addr", bb.mem_addr, 0);
        @(negedge clk);
        check("rm_nwr", bw_addr.size(), 0);
        @(posedge clk); #1 rst = 1'b1;
        pulse_start();
        send(OP_MEM, 6'b011001, 4'd4, 4'd3, 12'h008, 24'h0, 1'b1, acc);
        repeat (4) @(negedge clk);
        check("rm2_nwr", bw_addr.size(), 1);
        check("rm2_addr", bw_addr[0], 0);
        check("rm2_data", bw_data[0], 32'hE5943008);
        check("rm2_count", b_count, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
